// File: rtl/powlib_sfifo_pkg.sv
// Shared helpers for the powlib FIFO slice: pointer-width computation.
package powlib_sfifo_pkg;

  // Returns the ceiling of log2(v), which is the index width needed to address v entries.
  function automatic int powlib_clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/powlib_cntr.sv
// Wrapping up-counter with clear and optional load; async active-low reset.
module powlib_cntr #(
  parameter int W   = 3,
  parameter int ELD = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ldval,
  output logic [W-1:0] cntr
);

  // Natural W-bit overflow gives the modulo-2^W wrap with no special case.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cntr <= '0;
    else if (clr)             cntr <= '0;
    else if (ELD != 0 && ld)  cntr <= ldval;
    else if (adv)             cntr <= cntr + 1'b1;
  end

endmodule

// File: rtl/powlib_dpram.sv
// Dual-port RAM: synchronous write port, asynchronous read port, optional byte enables.
module powlib_dpram #(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = 3,
  parameter int EWBE = 0
) (
  input  logic                 clk,
  input  logic [W-1:0]         wrdata,
  input  logic [WIDX-1:0]      wridx,
  input  logic                 wrvld,
  input  logic [(W+7)/8-1:0]   wrbe,
  input  logic [WIDX-1:0]      rdidx,
  output logic [W-1:0]         rddata
);

  logic [W-1:0] mem [D];

  // Contents are never reset; the owning FIFO tracks validity through its pointers.
  always_ff @(posedge clk) begin
    if (wrvld) begin
      for (int i = 0; i < W; i++) begin
        if (EWBE == 0 || wrbe[i/8]) mem[wridx][i] <= wrdata[i];
      end
    end
  end

  assign rddata = mem[rdidx];

endmodule

// File: rtl/powlib_sfifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
module powlib_sfifo
  import powlib_sfifo_pkg::*;
#(
  parameter int W    = 16,
  parameter int D    = 8,
  parameter int WIDX = powlib_clogb2(D),
  parameter int AFT  = D - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  wrdata,
  input  logic          wrvld,
  output logic          wrrdy,
  output logic          wraf,
  output logic [W-1:0]  rddata,
  output logic          rdvld,
  input  logic          rdrdy,
  output logic [WIDX:0] count
);

  localparam logic [WIDX:0] CFULL = (WIDX+1)'(D);
  localparam logic [WIDX:0] CAFT  = (WIDX+1)'(AFT);

  logic            wfire, rfire;
  logic [WIDX-1:0] wrptr, rdptr;

  assign wrrdy = (count != CFULL);
  assign rdvld = (count != '0);
  assign wraf  = (count >= CAFT);
  assign wfire = wrvld & wrrdy;
  assign rfire = rdvld & rdrdy;

  powlib_dpram #(.W(W), .D(D), .WIDX(WIDX), .EWBE(0)) u_mem (
    .clk    (clk),
    .wrdata (wrdata),
    .wridx  (wrptr),
    .wrvld  (wfire),
    .wrbe   ('1),
    .rdidx  (rdptr),
    .rddata (rddata)
  );

  powlib_cntr #(.W(WIDX), .ELD(0)) u_wrptr (
    .clk   (clk),
    .rst   (rst),
    .adv   (wfire),
    .clr   (1'b0),
    .ld    (1'b0),
    .ldval ('0),
    .cntr  (wrptr)
  );

  powlib_cntr #(.W(WIDX), .ELD(0)) u_rdptr (
    .clk   (clk),
    .rst   (rst),
    .adv   (rfire),
    .clr   (1'b0),
    .ld    (1'b0),
    .ldval ('0),
    .cntr  (rdptr)
  );

  // Simultaneous push and pop cancel out, so occupancy only moves on a lone fire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case ({wfire, rfire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_powlib_sfifo.sv
// Directed bench for powlib_sfifo (W=16, D=8, AFT=6) with a count/order scoreboard for streaming.
module tb_powlib_sfifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] wrdata = '0;
  logic        wrvld = 1'b0;
  logic        wrrdy;
  logic        wraf;
  logic [15:0] rddata;
  logic        rdvld;
  logic        rdrdy = 1'b0;
  logic [3:0]  count;

  int tests = 0;
  int fails = 0;

  powlib_sfifo #(.W(16), .D(8), .AFT(6)) dut (
    .clk    (clk),
    .rst    (rst),
    .wrdata (wrdata),
    .wrvld  (wrvld),
    .wrrdy  (wrrdy),
    .wraf   (wraf),
    .rddata (rddata),
    .rdvld  (rdvld),
    .rdrdy  (rdrdy),
    .count  (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      assert (!$isunknown({wrvld, rdrdy})) else begin
        fails++;
        $error("FAIL xcheck: observed wrvld=%b rdrdy=%b required known values", wrvld, rdrdy);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mcount, wd, exp_rd, nwr, nrd;
    bit wf, rf;

    // Power-up reset
    step(); step();
    rst = 1'b1;
    step();
    chk("por_count", count, 0);
    chk("por_wrrdy", wrrdy, 1);
    chk("por_rdvld", rdvld, 0);
    chk("por_wraf", wraf, 0);

    // Reset mid-operation after 5 writes
    wrvld = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wrdata = 16'(i);
      step();
    end
    wrvld = 1'b0;
    chk("pre_rst_count", count, 5);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_wrrdy", wrrdy, 1);
    chk("async_rst_rdvld", rdvld, 0);
    chk("async_rst_wraf", wraf, 0);
    step(); step(); step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_count", count, 0);
      chk("idle_rdvld", rdvld, 0);
      chk("idle_wrrdy", wrrdy, 1);
      chk("idle_wraf", wraf, 0);
    end

    // Fill to full
    wrvld = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wrdata = 16'(i);
      step();
      chk("fill_count", count, 32'(i));
      chk("fill_wraf", wraf, (i >= 6) ? 1 : 0);
      chk("fill_rdvld", rdvld, 1);
    end
    chk("full_wrrdy", wrrdy, 0);
    wrdata = 16'h0009;
    step();
    chk("full_hold_count", count, 8);
    chk("full_hold_head", rddata, 16'h0001);
    wrvld = 1'b0;

    // Drain and order
    rdrdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_rdvld", rdvld, 1);
      chk("drain_data", rddata, 32'(i));
      step();
      if (i == 1) chk("drain_wrrdy", wrrdy, 1);
    end
    rdrdy = 1'b0;
    chk("drain_count", count, 0);
    chk("drain_rdvld_end", rdvld, 0);
    chk("drain_wraf_end", wraf, 0);

    // Simultaneous write and pop at full
    wrvld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wrdata = 16'(16'h0010 + i);
      step();
    end
    chk("refill_count", count, 8);
    wrdata = 16'h0018;
    rdrdy = 1'b1;
    step();
    chk("simfull_count", count, 7);
    chk("simfull_head", rddata, 16'h0011);
    rdrdy = 1'b0;
    step();
    chk("simfull_retry_count", count, 8);
    wrvld = 1'b0;
    rdrdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("simfull_drain", rddata, 32'(16'h0010 + i));
      step();
    end
    rdrdy = 1'b0;
    chk("simfull_empty", count, 0);

    // Empty plus write: pop request ignored, no bypass
    wrvld = 1'b1;
    rdrdy = 1'b1;
    wrdata = 16'hBEEF;
    chk("empty_rdvld", rdvld, 0);
    step();
    wrvld = 1'b0;
    rdrdy = 1'b0;
    chk("empty_wr_rdvld", rdvld, 1);
    chk("empty_wr_data", rddata, 16'hBEEF);
    chk("empty_wr_count", count, 1);
    rdrdy = 1'b1;
    step();
    rdrdy = 1'b0;
    chk("empty_wr_drained", count, 0);

    // Random streaming with scoreboard; runs until both pointers have lapped the ring 10+ times
    mcount = 0; wd = 16'h0100; exp_rd = 16'h0100; nwr = 0; nrd = 0;
    for (int c = 0; c < 2000 && (c < 100 || nrd < 88); c++) begin
      wrvld = 1'($urandom_range(0, 1));
      rdrdy = 1'($urandom_range(0, 1));
      wrdata = 16'(wd);
      wf = wrvld && (mcount != 8);
      rf = rdrdy && (mcount != 0);
      if (rf) chk("strm_data", rddata, 32'(exp_rd));
      step();
      if (wf) begin wd++; nwr++; mcount++; end
      if (rf) begin exp_rd++; nrd++; mcount--; end
      chk("strm_count", count, 32'(mcount));
      chk("strm_rdvld", rdvld, (mcount != 0) ? 1 : 0);
    end
    wrvld = 1'b0;
    rdrdy = 1'b0;
    chk("strm_wraps", (nrd >= 88 && nwr >= 88) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
